// File: rtl/id_operand_hold.sv
// rtl/id_operand_hold.sv - ID operand assembly with stall-time freeze and patching (optional counters: OPERAND_HOLD_STATS_EN)
module id_operand_hold #(
    parameter int ID_STALL_BIT = 2,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [5:0]    stall,
    input  logic [4:0]    rs_raddr,
    input  logic [4:0]    rt_raddr,
    input  logic [DW-1:0] rs_rf_rdata,
    input  logic [DW-1:0] rt_rf_rdata,
    input  logic          sel_rs_fwd,
    input  logic          sel_rt_fwd,
    input  logic [DW-1:0] rs_fwd_data,
    input  logic [DW-1:0] rt_fwd_data,
    input  logic          wb_we,
    input  logic [4:0]    wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    output logic [DW-1:0] rs_value,
    output logic [DW-1:0] rt_value,
    output logic          holding
`ifdef OPERAND_HOLD_STATS_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   hold_events
`endif
);

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q;
    logic [DW-1:0] rs_hold_q, rt_hold_q;
    logic [DW-1:0] rs_hold_d, rt_hold_d;
    logic [4:0]    rs_addr_q, rt_addr_q;

    logic          id_stall;
    logic [DW-1:0] rs_src, rt_src;
    logic          rs_hold_fwd, rt_hold_fwd;
    logic          rs_hold_wb, rt_hold_wb;

    // Only the ID bit of the shared stall bus matters here.
    logic unused_stall;
    assign unused_stall = ^stall;
    assign id_stall     = stall[ID_STALL_BIT];

    // Live operand: forward beats regfile, and register zero always reads zero.
    assign rs_src = (rs_raddr == 5'd0) ? '0 : (sel_rs_fwd ? rs_fwd_data : rs_rf_rdata);
    assign rt_src = (rt_raddr == 5'd0) ? '0 : (sel_rt_fwd ? rt_fwd_data : rt_rf_rdata);

    // While frozen, a forward or writeback aimed at the held register patches it.
    assign rs_hold_fwd = sel_rs_fwd && (rs_addr_q != 5'd0);
    assign rt_hold_fwd = sel_rt_fwd && (rt_addr_q != 5'd0);
    assign rs_hold_wb  = wb_we && (wb_waddr == rs_addr_q) && (rs_addr_q != 5'd0);
    assign rt_hold_wb  = wb_we && (wb_waddr == rt_addr_q) && (rt_addr_q != 5'd0);

    // Next hold value in HOLD: younger forward first, then writeback, else keep.
    always_comb begin
        rs_hold_d = rs_hold_q;
        rt_hold_d = rt_hold_q;
        if (rs_hold_fwd) begin
            rs_hold_d = rs_fwd_data;
        end else if (rs_hold_wb) begin
            rs_hold_d = wb_wdata;
        end
        if (rt_hold_fwd) begin
            rt_hold_d = rt_fwd_data;
        end else if (rt_hold_wb) begin
            rt_hold_d = wb_wdata;
        end
    end

    // In HOLD a same-cycle forward is shown directly so release-cycle load data is not missed.
    assign rs_value = (state_q == HOLD) ? (rs_hold_fwd ? rs_fwd_data : rs_hold_q) : rs_src;
    assign rt_value = (state_q == HOLD) ? (rt_hold_fwd ? rt_fwd_data : rt_hold_q) : rt_src;
    assign holding  = (state_q == HOLD);

    // PASS/HOLD sequencing: capture on stall entry, patch while held, flush discards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PASS;
            rs_hold_q <= '0;
            rt_hold_q <= '0;
            rs_addr_q <= 5'd0;
            rt_addr_q <= 5'd0;
        end else if (flush) begin
            state_q   <= PASS;
            rs_hold_q <= '0;
            rt_hold_q <= '0;
            rs_addr_q <= 5'd0;
            rt_addr_q <= 5'd0;
        end else begin
            case (state_q)
                PASS: begin
                    if (id_stall) begin
                        state_q   <= HOLD;
                        rs_hold_q <= rs_src;
                        rt_hold_q <= rt_src;
                        rs_addr_q <= rs_raddr;
                        rt_addr_q <= rt_raddr;
                    end
                end
                HOLD: begin
                    rs_hold_q <= rs_hold_d;
                    rt_hold_q <= rt_hold_d;
                    if (!id_stall) begin
                        state_q <= PASS;
                    end
                end
                default: state_q <= PASS;
            endcase
        end
    end

`ifdef OPERAND_HOLD_STATS_EN
    logic [31:0] stall_cycles_q, hold_events_q;

    // Performance counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            hold_events_q  <= 32'd0;
        end else begin
            if (state_q == HOLD) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((state_q == PASS) && id_stall && !flush) begin
                hold_events_q <= hold_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign hold_events  = hold_events_q;
`endif

endmodule

// File: tb/tb_id_operand_hold.sv
// tb/tb_id_operand_hold.sv - self-checking bench for id_operand_hold
module tb_id_operand_hold;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, flush, wb_we;
    logic [5:0]    stall;
    logic [4:0]    rs_raddr, rt_raddr, wb_waddr;
    logic [DW-1:0] rs_rf_rdata, rt_rf_rdata, rs_fwd_data, rt_fwd_data, wb_wdata;
    logic          sel_rs_fwd, sel_rt_fwd;
    logic [DW-1:0] rs_value, rt_value;
    logic          holding;
`ifdef OPERAND_HOLD_STATS_EN
    logic [31:0]   stall_cycles, hold_events;
`endif

    always #5 clk = ~clk;

    id_operand_hold #(.ID_STALL_BIT(2), .DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .rs_raddr(rs_raddr), .rt_raddr(rt_raddr),
        .rs_rf_rdata(rs_rf_rdata), .rt_rf_rdata(rt_rf_rdata),
        .sel_rs_fwd(sel_rs_fwd), .sel_rt_fwd(sel_rt_fwd),
        .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .rs_value(rs_value), .rt_value(rt_value), .holding(holding)
`ifdef OPERAND_HOLD_STATS_EN
        , .stall_cycles(stall_cycles), .hold_events(hold_events)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the instruction in ID either reads live operands or
    // remembers the newest value known for the register it is waiting on.
    bit          m_valid = 1'b0;
    bit          m_frozen;
    logic [31:0] m_rs_val, m_rt_val;
    logic [4:0]  m_rs_reg, m_rt_reg;
    logic [31:0] m_cycles, m_events;

    function automatic logic [31:0] live_operand(input logic [4:0] r, input bit sel,
                                                 input logic [31:0] fwd, input logic [31:0] rf);
        if (r == 0) return 32'd0;
        return sel ? fwd : rf;
    endfunction

    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] known,
                                           input bit sel, input logic [31:0] fwd,
                                           input bit we, input logic [4:0] wa, input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (sel) return fwd;
        if (we && wa == r) return wd;
        return known;
    endfunction

    // Compare every cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        logic [31:0] e_rs, e_rt;
        if (m_valid) begin
            if (m_frozen) begin
                e_rs = newest(m_rs_reg, m_rs_val, sel_rs_fwd, rs_fwd_data, 1'b0, 5'd0, 32'd0);
                e_rt = newest(m_rt_reg, m_rt_val, sel_rt_fwd, rt_fwd_data, 1'b0, 5'd0, 32'd0);
            end else begin
                e_rs = live_operand(rs_raddr, sel_rs_fwd, rs_fwd_data, rs_rf_rdata);
                e_rt = live_operand(rt_raddr, sel_rt_fwd, rt_fwd_data, rt_rf_rdata);
            end
            if (!flush) begin
                chk("model_rs_value", rs_value, e_rs);
                chk("model_rt_value", rt_value, e_rt);
            end
            chk("model_holding", {31'd0, holding}, {31'd0, m_frozen});
`ifdef OPERAND_HOLD_STATS_EN
            chk("model_stall_cycles", stall_cycles, m_cycles);
            chk("model_hold_events", hold_events, m_events);
`endif
        end
        if (rst) begin
            m_valid  = 1'b1;
            m_frozen = 1'b0;
            m_rs_val = 0; m_rt_val = 0; m_rs_reg = 0; m_rt_reg = 0;
            m_cycles = 0; m_events = 0;
        end else if (m_valid) begin
            if (m_frozen) m_cycles = m_cycles + 1;
            if (flush) begin
                m_frozen = 1'b0;
                m_rs_val = 0;
                m_rt_val = 0;
            end else if (!m_frozen) begin
                if (stall[2]) begin
                    m_frozen = 1'b1;
                    m_events = m_events + 1;
                    m_rs_reg = rs_raddr;
                    m_rt_reg = rt_raddr;
                    m_rs_val = live_operand(rs_raddr, sel_rs_fwd, rs_fwd_data, rs_rf_rdata);
                    m_rt_val = live_operand(rt_raddr, sel_rt_fwd, rt_fwd_data, rt_rf_rdata);
                end
            end else begin
                m_rs_val = newest(m_rs_reg, m_rs_val, sel_rs_fwd, rs_fwd_data, wb_we, wb_waddr, wb_wdata);
                m_rt_val = newest(m_rt_reg, m_rt_val, sel_rt_fwd, rt_fwd_data, wb_we, wb_waddr, wb_wdata);
                if (!stall[2]) m_frozen = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; stall = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        rs_raddr = 0; rt_raddr = 0; rs_rf_rdata = 0; rt_rf_rdata = 0;
        sel_rs_fwd = 0; sel_rt_fwd = 0; rs_fwd_data = 0; rt_fwd_data = 0;
    endtask

    function automatic logic [4:0] pick_addr();
        logic [4:0] tbl [5];
        tbl[0] = 5'd0; tbl[1] = 5'd1; tbl[2] = 5'd2; tbl[3] = 5'd9; tbl[4] = 5'd31;
        return tbl[$urandom_range(4, 0)];
    endfunction

    initial begin
        int lens [3];
        idle_inputs();
        rst = 1;
        next_cycle();
        rst = 0;

        @(negedge clk);
        chk("reset_holding", {31'd0, holding}, 32'd0);
        chk("reset_rs_value", rs_value, 32'd0);
        next_cycle();

        rs_raddr = 5; rs_rf_rdata = 32'h11;
        @(negedge clk);
        chk("pass_rf", rs_value, 32'h11);
        chk("pass_holding", {31'd0, holding}, 32'd0);
        next_cycle();

        sel_rs_fwd = 1; rs_fwd_data = 32'hAB;
        @(negedge clk);
        chk("pass_fwd", rs_value, 32'hAB);
        next_cycle();
        rs_raddr = 0;
        @(negedge clk);
        chk("pass_addr0", rs_value, 32'h0);
        next_cycle();

        idle_inputs();
        rs_raddr = 5; rs_rf_rdata = 32'h11; stall = 6'b000100;
        @(negedge clk);
        chk("lu_c1_holding", {31'd0, holding}, 32'd0);
        chk("lu_c1_rs", rs_value, 32'h11);
        next_cycle();
        @(negedge clk);
        chk("lu_c2_holding", {31'd0, holding}, 32'd1);
        next_cycle();
        stall = 0; sel_rs_fwd = 1; rs_fwd_data = 32'hDEAD;
        @(negedge clk);
        chk("lu_release_holding", {31'd0, holding}, 32'd1);
        chk("lu_release_rs", rs_value, 32'hDEAD);
        next_cycle();
        sel_rs_fwd = 0; rs_rf_rdata = 32'h22;
        @(negedge clk);
        chk("lu_after_holding", {31'd0, holding}, 32'd0);
        chk("lu_after_rs", rs_value, 32'h22);
        next_cycle();

        idle_inputs();
        rt_raddr = 9; rt_rf_rdata = 32'h5; stall = 6'b000100;
        next_cycle();
        wb_we = 1; wb_waddr = 9; wb_wdata = 32'h77; rt_rf_rdata = 32'h99;
        @(negedge clk);
        chk("wb_hold_before", rt_value, 32'h5);
        next_cycle();
        wb_we = 0; stall = 0;
        @(negedge clk);
        chk("wb_patch_release", rt_value, 32'h77);
        next_cycle();

        idle_inputs();
        rt_raddr = 9; rt_rf_rdata = 32'h5; stall = 6'b000100;
        next_cycle();
        wb_we = 1; wb_waddr = 9; wb_wdata = 32'h77; sel_rt_fwd = 1; rt_fwd_data = 32'h88;
        @(negedge clk);
        chk("fwd_vs_wb_same", rt_value, 32'h88);
        next_cycle();
        wb_we = 0; sel_rt_fwd = 0; stall = 0;
        @(negedge clk);
        chk("fwd_vs_wb_release", rt_value, 32'h88);
        next_cycle();

        idle_inputs();
        rs_raddr = 5; rs_rf_rdata = 32'h33; stall = 6'b000100;
        next_cycle();
        flush = 1;
        @(negedge clk);
        chk("flush_in_hold", {31'd0, holding}, 32'd1);
        next_cycle();
        flush = 0; stall = 0; rs_rf_rdata = 32'h44;
        @(negedge clk);
        chk("flush_after_holding", {31'd0, holding}, 32'd0);
        chk("flush_after_rs", rs_value, 32'h44);
        next_cycle();

        idle_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
        lens[0] = 1; lens[1] = 3; lens[2] = 2;
        for (int k = 0; k < 3; k++) begin
            stall = 6'b000100;
            for (int c = 0; c < lens[k]; c++) next_cycle();
            stall = 0;
            next_cycle();
            next_cycle();
        end
`ifdef OPERAND_HOLD_STATS_EN
        @(negedge clk);
        chk("stats_events", hold_events, 32'd3);
        chk("stats_cycles", stall_cycles, 32'd6);
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("stats_rst_events", hold_events, 32'd0);
        chk("stats_rst_cycles", stall_cycles, 32'd0);
        next_cycle();
`endif

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(199, 0) == 0);
            flush       = ($urandom_range(24, 0) == 0);
            stall       = 6'($urandom) & 6'b111011;
            stall[2]    = ($urandom_range(99, 0) < 45);
            rs_raddr    = pick_addr();
            rt_raddr    = pick_addr();
            rs_rf_rdata = $urandom;
            rt_rf_rdata = $urandom;
            sel_rs_fwd  = ($urandom_range(3, 0) == 0);
            sel_rt_fwd  = ($urandom_range(3, 0) == 0);
            rs_fwd_data = $urandom;
            rt_fwd_data = $urandom;
            wb_we       = ($urandom_range(1, 0) == 0);
            wb_waddr    = pick_addr();
            wb_wdata    = $urandom;
            next_cycle();
        end

        idle_inputs();
        rst = 0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
